// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode/issue into a single-entry ID/EX register (operands, ALU select, control flags).
// Latency: 1 cycle from in_valid&in_ready to out_valid; outputs hold while out_valid & !out_ready.
// Backpressure: in_ready = (!out_valid | out_ready) & !stall; flush drops held and incoming entries.
// Option: define FORWARDING_EN to forward EX/WB results and stall only on load-use.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic [REG_AW-1:0] rf_rs1_addr,
  output logic [REG_AW-1:0] rf_rs2_addr,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic              flush,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              ex_is_load,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_branch,
  output logic [3:0]        out_func3,
  output logic [XLEN-1:0]   out_op_a,
  output logic [XLEN-1:0]   out_op_b,
  output logic [XLEN-1:0]   out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic              out_jump,
  output logic              out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic              branch;
    logic [3:0]        func3;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              mem_rd;
    logic              mem_wr;
    logic              jump;
    logic              illegal;
  } idex_t;

  // Sign-extend a 32-bit immediate to the datapath width.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              rs1_used, rs2_used;
  logic              ex_hit1, ex_hit2, wb_hit1, wb_hit2;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic              stall, fire;
  idex_t             dec;
  idex_t             pl_q, pl_d;
  logic              out_valid_q, out_valid_d;

  assign opcode      = in_instr[6:0];
  assign funct3      = in_instr[14:12];
  assign rs1         = in_instr[19:15];
  assign rs2         = in_instr[24:20];
  assign rd          = in_instr[11:7];
  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  // Which register fields are real sources, so immediate bits never raise false hazards.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode)
      OPC_OP, OPC_BRANCH, OPC_STORE: begin rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: rs1_used = 1'b1;
      default: ;
    endcase
  end

  // x0 never matches: it neither forwards nor stalls.
  assign ex_hit1 = rs1_used && (rs1 != '0) && ex_we && (ex_rd == rs1);
  assign ex_hit2 = rs2_used && (rs2 != '0) && ex_we && (ex_rd == rs2);
  assign wb_hit1 = rs1_used && (rs1 != '0) && wb_we && (wb_rd == rs1);
  assign wb_hit2 = rs2_used && (rs2 != '0) && wb_we && (wb_rd == rs2);

`ifdef FORWARDING_EN
  // EX result is younger than WB, so it wins; only a load in EX has no data yet.
  assign rs1_val = ex_hit1 ? ex_data : (wb_hit1 ? wb_data : rf_rs1_data);
  assign rs2_val = ex_hit2 ? ex_data : (wb_hit2 ? wb_data : rf_rs2_data);
  assign stall   = (ex_hit1 || ex_hit2) && ex_is_load;
`else
  // Without bypass paths any pending write to a source holds the instruction.
  logic unused_fwd;
  assign unused_fwd = ^{ex_data, wb_data, ex_is_load};
  assign rs1_val    = rf_rs1_data;
  assign rs2_val    = rf_rs2_data;
  assign stall      = ex_hit1 || ex_hit2 || wb_hit1 || wb_hit2;
`endif

  assign in_ready = (!out_valid_q || out_ready) && !stall;
  assign fire     = in_valid && in_ready;

  // Decode the offered instruction into the ID/EX payload.
  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.rd    = rd;
    dec.rs2   = rs2_val;
    dec.op_a  = rs1_val;
    dec.op_b  = rs2_val;
    unique case (opcode)
      OPC_OP: begin
        dec.func3 = {in_instr[30], funct3};
        dec.rd_we = 1'b1;
      end
      OPC_OPIMM: begin
        dec.imm   = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        dec.rd_we = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shifts: bit 30 selects arithmetic right shift, operand is the raw shamt.
          dec.func3 = {in_instr[30], funct3};
          dec.op_b  = XLEN'(in_instr[24:20]);
        end else begin
          dec.func3 = {1'b0, funct3};
          dec.op_b  = dec.imm;
        end
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.func3  = {1'b0, funct3};
        dec.imm    = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0});
      end
      OPC_LOAD: begin
        dec.imm    = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        dec.op_b   = dec.imm;
        dec.mem_rd = 1'b1;
        dec.rd_we  = 1'b1;
      end
      OPC_STORE: begin
        dec.imm    = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
        dec.op_b   = dec.imm;
        dec.mem_wr = 1'b1;
      end
      OPC_LUI: begin
        dec.imm   = sext32({in_instr[31:12], 12'b0});
        dec.op_a  = '0;
        dec.op_b  = dec.imm;
        dec.rd_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm   = sext32({in_instr[31:12], 12'b0});
        dec.op_a  = in_pc;
        dec.op_b  = dec.imm;
        dec.rd_we = 1'b1;
      end
      OPC_JAL: begin
        dec.imm   = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0});
        dec.op_a  = in_pc;
        dec.jump  = 1'b1;
        dec.rd_we = 1'b1;
      end
      OPC_JALR: begin
        dec.imm   = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        dec.jump  = 1'b1;
        dec.rd_we = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (rd == '0) dec.rd_we = 1'b0;
  end

  // Next state of the pipeline entry: flush kills, capture on transfer, drain on consume.
  always_comb begin
    out_valid_d = out_valid_q;
    pl_d        = pl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d = 1'b1;
      pl_d        = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ID/EX register; reset clears the held entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pl_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pl_q        <= pl_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_branch  = pl_q.branch;
  assign out_func3   = pl_q.func3;
  assign out_op_a    = pl_q.op_a;
  assign out_op_b    = pl_q.op_b;
  assign out_rs2     = pl_q.rs2;
  assign out_imm     = pl_q.imm;
  assign out_pc      = pl_q.pc;
  assign out_rd      = pl_q.rd;
  assign out_rd_we   = pl_q.rd_we;
  assign out_mem_rd  = pl_q.mem_rd;
  assign out_mem_wr  = pl_q.mem_wr;
  assign out_jump    = pl_q.jump;
  assign out_illegal = pl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for id_ex_stage with hand-computed expectations.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: exercised via out_ready stalls, flush and hazard holds.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        flush;
  logic        ex_we, ex_is_load, wb_we;
  logic [4:0]  ex_rd, wb_rd;
  logic [31:0] ex_data, wb_data;
  logic        out_valid, out_ready, out_branch;
  logic [3:0]  out_func3;
  logic [31:0] out_op_a, out_op_b, out_rs2, out_imm, out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_mem_rd, out_mem_wr, out_jump, out_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h40335293;
  localparam logic [31:0] I_ADDI = 32'hC0000093;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_BAD  = 32'h000001FF;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .flush(flush),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data), .ex_is_load(ex_is_load),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_branch(out_branch), .out_func3(out_func3),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_pc(out_pc), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_mem_rd(out_mem_rd),
    .out_mem_wr(out_mem_wr), .out_jump(out_jump), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_pc       = pc;
    rf_rs1_data = d1;
    rf_rs2_data = d2;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2);
    offer(instr, pc, d1, d2);
    out_ready = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rf_rs1_data = '0; rf_rs2_data = '0; flush = 1'b0;
    ex_we = 1'b0; ex_rd = '0; ex_data = '0; ex_is_load = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    #3;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_op_a", out_op_a, 32'd0);
    check("reset_func3", 32'(out_func3), 32'd0);
    check("reset_rd_we", 32'(out_rd_we), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    #9 rst_n = 1'b1;
    step();

    // ADD x3, x1, x2
    offer(I_ADD, 32'h40, 32'd5, 32'd7);
    #1;
    check("add_rs1_addr", 32'(rf_rs1_addr), 32'd1);
    check("add_rs2_addr", 32'(rf_rs2_addr), 32'd2);
    check("add_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_func3", 32'(out_func3), 32'd0);
    check("add_branch", 32'(out_branch), 32'd0);
    check("add_op_a", out_op_a, 32'd5);
    check("add_op_b", out_op_b, 32'd7);
    check("add_rd", 32'(out_rd), 32'd3);
    check("add_rd_we", 32'(out_rd_we), 32'd1);
    check("add_pc", out_pc, 32'h40);

    issue(I_SUB, 32'h44, 32'd9, 32'd4);
    check("sub_func3", 32'(out_func3), 32'd8);
    check("sub_op_b", out_op_b, 32'd4);

    issue(I_SRAI, 32'h48, 32'h8000_0000, 32'd77);
    check("srai_func3", 32'(out_func3), 32'd13);
    check("srai_op_b", out_op_b, 32'd3);
    check("srai_op_a", out_op_a, 32'h8000_0000);
    check("srai_rd", 32'(out_rd), 32'd5);

    issue(I_ADDI, 32'h4C, 32'd0, 32'd0);
    check("addi_func3", 32'(out_func3), 32'd0);
    check("addi_op_b", out_op_b, 32'hFFFF_FC00);
    check("addi_imm", out_imm, 32'hFFFF_FC00);

    issue(I_BLT, 32'h50, 32'd11, 32'd22);
    check("blt_branch", 32'(out_branch), 32'd1);
    check("blt_func3", 32'(out_func3), 32'd4);
    check("blt_op_a", out_op_a, 32'd11);
    check("blt_op_b", out_op_b, 32'd22);
    check("blt_imm", out_imm, 32'd8);
    check("blt_rd_we", 32'(out_rd_we), 32'd0);

    issue(I_BAD, 32'h54, 32'd1, 32'd2);
    check("bad_illegal", 32'(out_illegal), 32'd1);
    check("bad_rd_we", 32'(out_rd_we), 32'd0);

    issue(I_LUI, 32'h58, 32'd99, 32'd98);
    check("lui_op_a", out_op_a, 32'd0);
    check("lui_op_b", out_op_b, 32'h1234_5000);
    check("lui_rd_we", 32'(out_rd_we), 32'd1);
    check("lui_illegal", 32'(out_illegal), 32'd0);

    // Asynchronous reset while an entry is held
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_op_b", out_op_b, 32'd0);
    rst_n = 1'b1;
    step();

    // Backpressure: capture ADD, then hold for 3 cycles while SUB waits
    offer(I_ADD, 32'h100, 32'd11, 32'd22);
    out_ready = 1'b0;
    #1;
    step();
    offer(I_SUB, 32'h104, 32'd99, 32'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_op_a", out_op_a, 32'd11);
      check("bp_func3", 32'(out_func3), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_next_func3", 32'(out_func3), 32'd8);
    check("bp_next_op_a", out_op_a, 32'd99);
    step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Flush with an incoming instruction
    offer(I_ADD, 32'h200, 32'd1, 32'd2);
    flush = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_in_valid", 32'(out_valid), 32'd0);
    step();
    check("flush_no_late", 32'(out_valid), 32'd0);

    // Flush of a held entry
    offer(I_ADD, 32'h210, 32'd1, 32'd2);
    out_ready = 1'b0;
    #1;
    step();
    in_valid = 1'b0;
    check("flush_held_pre", 32'(out_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    check("flush_held", 32'(out_valid), 32'd0);

    // EX hazard on rs1
    ex_we = 1'b1; ex_rd = 5'd1; ex_data = 32'hDEAD;
    offer(I_ADD, 32'h300, 32'd5, 32'd7);
    #1;
`ifdef FORWARDING_EN
    check("exfwd_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("exfwd_op_a", out_op_a, 32'hDEAD);
    ex_we = 1'b0;
`else
    check("exhaz_in_ready", 32'(in_ready), 32'd0);
    step();
    check("exhaz_no_issue", 32'(out_valid), 32'd0);
    check("exhaz_still", 32'(in_ready), 32'd0);
    ex_we = 1'b0;
    #1;
    check("exhaz_cleared", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("exhaz_valid", 32'(out_valid), 32'd1);
    check("exhaz_op_a", out_op_a, 32'd5);
`endif

    // Load-use on rs2 stalls in every build
    ex_we = 1'b1; ex_rd = 5'd2; ex_is_load = 1'b1;
    offer(I_ADD, 32'h310, 32'd5, 32'd7);
    #1;
    check("loaduse_in_ready", 32'(in_ready), 32'd0);
    ex_we = 1'b0; ex_is_load = 1'b0; in_valid = 1'b0;
    step();

    // WB hazard on rs2
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hBEEF;
    offer(I_ADD, 32'h320, 32'd5, 32'd7);
    #1;
`ifdef FORWARDING_EN
    check("wbfwd_in_ready", 32'(in_ready), 32'd1);
    step();
    check("wbfwd_op_b", out_op_b, 32'hBEEF);
    check("wbfwd_rs2", out_rs2, 32'hBEEF);
`else
    check("wbhaz_in_ready", 32'(in_ready), 32'd0);
`endif
    in_valid = 1'b0; wb_we = 1'b0;
    step();

    // x0 in EX never forwards or stalls
    ex_we = 1'b1; ex_rd = 5'd0; ex_data = 32'hDEAD;
    offer(I_ADDI, 32'h330, 32'h33, 32'd0);
    #1;
    check("x0_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; ex_we = 1'b0;
    check("x0_op_a", out_op_a, 32'h33);
    check("x0_valid", 32'(out_valid), 32'd1);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
